// File: rtl/hazard_sequencer.sv
// Pipeline sequencer: stall/flush/bubble controls for load-use, dmem wait, redirect, halt/drain.
// Latency: controls are Mealy (same cycle as the event); FSM state and counters update on posedge clk.
// Backpressure: a dmem wait freezes IF..EX/MEM and bubbles MEM/WB; everything else is deferred behind it.
//
// Ports:
//   clk, resetn                              clock, async active-low reset
//   id_*                                     OF-stage instruction (valid, rs1/rs2 index and use flags)
//   ex_valid, ex_is_load, ex_rd              EX-stage instruction
//   mem_valid, wb_valid                      MEM/WB occupancy, used to detect an empty pipe
//   mem_req_valid, mem_ready                 data-memory handshake
//   br_taken                                 EX redirect
//   halt_req                                 level request to drain and halt
//   stall_*, flush_*, bubble_memwb           per pipeline-register controls
//   halted, fsm_state, stall_cycles          status and saturating stall-cycle counter
module hazard_sequencer #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             mem_valid,
  input  logic             wb_valid,
  input  logic             mem_req_valid,
  input  logic             mem_ready,
  input  logic             br_taken,
  input  logic             halt_req,
  output logic             stall_if,
  output logic             stall_ifof,
  output logic             stall_ofex,
  output logic             stall_exmem,
  output logic             stall_memwb,
  output logic             flush_ifof,
  output logic             flush_ofex,
  output logic             bubble_memwb,
  output logic             halted,
  output logic [2:0]       fsm_state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    LDSTALL = 3'd1,
    DRAIN   = 3'd2,
    HALTED  = 3'd3
  } state_t;

  // Remaining bubbles after the first one, which is issued in the cycle the hazard is seen.
  localparam logic [2:0] BUB_LOAD = 3'(LOAD_USE_BUBBLES - 1);

  state_t     state, state_nxt;
  logic [2:0] bub_cnt, bub_nxt;

  logic mem_wait;
  logic load_use;
  logic pipe_empty;

  // Action selects; the output mapping below turns these into register controls.
  logic do_mem;      // freeze IF..EX/MEM, NOP into MEM/WB
  logic do_lu;       // hold IF and IF/OF, NOP into OF/EX
  logic do_redirect; // squash IF/OF and OF/EX, PC takes the redirect
  logic do_hold;     // hold PC, feed NOPs into IF/OF while draining or halted

  assign mem_wait   = mem_req_valid && !mem_ready;
  assign load_use   = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));
  assign pipe_empty = !id_valid && !ex_valid && !mem_valid && !wb_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= RUN;
      bub_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bub_nxt     = bub_cnt;
    do_mem      = 1'b0;
    do_lu       = 1'b0;
    do_redirect = 1'b0;
    do_hold     = 1'b0;
    halted      = 1'b0;

    case (state)
      RUN: begin
        if (mem_wait) begin
          do_mem = 1'b1;
        end else if (br_taken) begin
          do_redirect = 1'b1;
        end else if (load_use) begin
          do_lu   = 1'b1;
          bub_nxt = BUB_LOAD;
          if (BUB_LOAD != 3'd0) state_nxt = LDSTALL;
        end else if (halt_req) begin
          state_nxt = DRAIN;
        end
      end

      LDSTALL: begin
        if (mem_wait) begin
          do_mem = 1'b1;
        end else begin
          // A redirect cannot legally appear here: EX holds a bubble.
          do_lu   = 1'b1;
          bub_nxt = bub_cnt - 3'd1;
          if (bub_cnt == 3'd1) state_nxt = RUN;
        end
      end

      DRAIN: begin
        if (mem_wait) begin
          do_mem = 1'b1;
        end else begin
          if (load_use)      do_lu       = 1'b1;
          else if (br_taken) do_redirect = 1'b1;
          else               do_hold     = 1'b1;

          // A load-use cycle keeps the drain going; the bubble must land first.
          if (!load_use) begin
            if (!halt_req)       state_nxt = RUN;
            else if (pipe_empty) state_nxt = HALTED;
          end
        end
      end

      HALTED: begin
        // Pipe is empty, so a dmem wait cannot be ours to honour.
        do_hold = 1'b1;
        halted  = 1'b1;
        if (!halt_req) state_nxt = RUN;
      end

      default: begin
        state_nxt = RUN;
        bub_nxt   = 3'd0;
      end
    endcase
  end

  // Stall wins over flush on the same register.
  assign stall_if     = do_mem || do_lu || do_hold;
  assign stall_ifof   = do_mem || do_lu;
  assign stall_ofex   = do_mem;
  assign stall_exmem  = do_mem;
  assign stall_memwb  = 1'b0;
  assign bubble_memwb = do_mem;
  assign flush_ifof   = (do_redirect || do_hold) && !stall_ifof;
  assign flush_ofex   = (do_redirect || do_lu) && !stall_ofex;
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
    end else if (stall_if && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  a_no_redirect_in_ldstall: assert property (@(posedge clk) disable iff (!resetn)
    !((state == LDSTALL) && !mem_wait && br_taken));

  a_stall_chain: assert property (@(posedge clk) disable iff (!resetn)
    (!stall_exmem || stall_ofex) && (!stall_ofex || stall_ifof) && (!stall_ifof || stall_if));

endmodule
